// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding instruction memory requests and the IF/ID register.
// Handles stall buffering, branch redirects and flushes.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush_if_id,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_DROP, S_HOLD} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_buf_instr;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;

    logic [31:0] w_target;
    logic [31:0] w_pc_inc;
    logic        w_deliver;
    logic [31:0] w_dl_instr;

    assign w_target = {branch_target[31:2], 2'b00};
    assign w_pc_inc = r_pc + 32'd4;

    // Delivery source: the live response in S_WAIT, the stall buffer in S_HOLD
    always_comb begin
        w_deliver  = 1'b0;
        w_dl_instr = imem_rdata;
        case (r_state)
            S_WAIT: w_deliver = imem_valid && !branch_taken && !stall;
            S_HOLD: begin
                w_deliver  = !branch_taken && !stall;
                w_dl_instr = r_buf_instr;
            end
            default: ;
        endcase
    end

    assign imem_req    = rst_n && (r_state == S_ISSUE) && !stall && !branch_taken;
    assign imem_addr   = r_pc;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_valid = r_if_id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_ISSUE;
            r_pc          <= RESET_PC;
            r_buf_instr   <= '0;
            r_if_id_pc    <= '0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else begin
            case (r_state)
                S_ISSUE: begin
                    if (branch_taken)
                        r_pc <= w_target;
                    else if (!stall)
                        r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_valid) begin
                        r_state <= S_ISSUE;
                        if (branch_taken) begin
                            r_pc <= w_target;
                        end else if (stall) begin
                            r_buf_instr <= imem_rdata;
                            r_state     <= S_HOLD;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end else if (branch_taken) begin
                        r_pc    <= w_target;
                        r_state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (branch_taken)
                        r_pc <= w_target;
                    if (imem_valid)
                        r_state <= S_ISSUE;
                end
                S_HOLD: begin
                    if (branch_taken) begin
                        r_pc    <= w_target;
                        r_state <= S_ISSUE;
                    end else if (!stall) begin
                        r_pc    <= w_pc_inc;
                        r_state <= S_ISSUE;
                    end
                end
                default: r_state <= S_ISSUE;
            endcase

            // Flush wins over a same-cycle delivery; the PC still advances above
            if (flush_if_id) begin
                r_if_id_pc    <= '0;
                r_if_id_instr <= NOP_INSTR;
                r_if_id_valid <= 1'b0;
            end else if (!stall) begin
                if (w_deliver) begin
                    r_if_id_pc    <= r_pc;
                    r_if_id_instr <= w_dl_instr;
                    r_if_id_valid <= 1'b1;
                end else begin
                    r_if_id_pc    <= '0;
                    r_if_id_instr <= NOP_INSTR;
                    r_if_id_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, reset corner sequence,
// and randomized traffic against a transaction-level reference model.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, flush_if_id = 1'b0, branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] if_id_pc, if_id_instr;
    logic        if_id_valid;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    fetch_unit #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush_if_id(flush_if_id),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          s, f, b;
        logic [31:0] t;
        bit          v;
        logic [31:0] d;
        bit          er;
        logic [31:0] ea;
        bit          evld;
        logic [31:0] epc, ein;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit s, bit f, bit b, logic [31:0] t, bit v, logic [31:0] d,
                                bit er, logic [31:0] ea, bit evld, logic [31:0] epc, logic [31:0] ein);
        vec_t r;
        r.s = s; r.f = f; r.b = b; r.t = t; r.v = v; r.d = d;
        r.er = er; r.ea = ea; r.evld = evld; r.epc = epc; r.ein = ein;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit s, input bit f, input bit b, input logic [31:0] t,
                         input bit v, input logic [31:0] d);
        stall = s; flush_if_id = f; branch_taken = b; branch_target = t;
        imem_valid = v; imem_rdata = d;
    endtask

    task automatic chk_ifid(input string tag, input bit v, input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
        chk({tag, ".pc"},    if_id_pc, pc);
        chk({tag, ".instr"}, if_id_instr, ins);
    endtask

    // Holds reset for two cycles, checks reset outputs, releases on a falling edge
    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, '0, 0, '0);
        repeat (2) @(negedge clk);
        chk("rst.req", {31'd0, imem_req}, 32'd0);
        chk("rst.addr", imem_addr, RPC);
        chk_ifid("rst", 0, 32'd0, NOP);
        rst_n = 1'b1;
    endtask

    // Reference model: outstanding-request flag, discard flag, held word
    bit          m_out, m_kill, m_held;
    logic [31:0] m_pc, m_hinstr, m_ipc, m_iins;
    bit          m_ivld;

    task automatic model_reset();
        m_out = 0; m_kill = 0; m_held = 0; m_pc = RPC; m_hinstr = '0;
        m_ipc = '0; m_iins = NOP; m_ivld = 0;
    endtask

    task automatic model_step(input bit s, input bit f, input bit b, input logic [31:0] t,
                              input bit v, input logic [31:0] d);
        logic [31:0] tg, dpc, di;
        bit dl;
        tg = t & 32'hFFFF_FFFC;
        dpc = m_pc; di = '0; dl = 0;
        if (m_out) begin
            if (v) begin
                m_out = 0;
                if (m_kill || b) begin
                    m_kill = 0;
                    if (b) m_pc = tg;
                end else if (s) begin
                    m_held = 1; m_hinstr = d;
                end else begin
                    dl = 1; di = d; m_pc = m_pc + 32'd4;
                end
            end else if (b) begin
                m_pc = tg; m_kill = 1;
            end
        end else if (m_held) begin
            if (b) begin
                m_held = 0; m_pc = tg;
            end else if (!s) begin
                dl = 1; di = m_hinstr; m_held = 0; m_pc = m_pc + 32'd4;
            end
        end else if (b) begin
            m_pc = tg;
        end else if (!s) begin
            m_out = 1;
        end
        if (f) begin
            m_ipc = '0; m_iins = NOP; m_ivld = 0;
        end else if (!s) begin
            if (dl) begin
                m_ipc = dpc; m_iins = di; m_ivld = 1;
            end else begin
                m_ipc = '0; m_iins = NOP; m_ivld = 0;
            end
        end
    endtask

    initial begin
        // s f b target v data | req addr | ifv ifpc ifinstr
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        1,32'h0,        0,32'h0,        NOP));
        tbl.push_back(mk(0,0,0,32'h0,        1,32'h00500093, 0,32'h0,        1,32'h0,        32'h00500093));
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        1,32'h4,        0,32'h0,        NOP));
        tbl.push_back(mk(0,0,0,32'h0,        1,32'h11111111, 0,32'h0,        1,32'h4,        32'h11111111));
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        1,32'h8,        0,32'h0,        NOP));
        tbl.push_back(mk(1,0,0,32'h0,        1,32'h22222222, 0,32'h0,        0,32'h0,        NOP));
        tbl.push_back(mk(1,0,0,32'h0,        0,32'h0,        0,32'h0,        0,32'h0,        NOP));
        tbl.push_back(mk(1,0,0,32'h0,        0,32'h0,        0,32'h0,        0,32'h0,        NOP));
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        0,32'h0,        1,32'h8,        32'h22222222));
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        1,32'hC,        0,32'h0,        NOP));
        tbl.push_back(mk(0,1,1,32'h100,      0,32'h0,        0,32'h0,        0,32'h0,        NOP));
        tbl.push_back(mk(0,0,0,32'h0,        1,32'hDEAD0000, 0,32'h0,        0,32'h0,        NOP));
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        1,32'h100,      0,32'h0,        NOP));
        tbl.push_back(mk(0,0,1,32'h203,      1,32'h33333333, 0,32'h0,        0,32'h0,        NOP));
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        1,32'h200,      0,32'h0,        NOP));
        tbl.push_back(mk(0,0,0,32'h0,        1,32'h44444444, 0,32'h0,        1,32'h200,      32'h44444444));
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        1,32'h204,      0,32'h0,        NOP));
        tbl.push_back(mk(0,1,0,32'h0,        1,32'h55555555, 0,32'h0,        0,32'h0,        NOP));
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        1,32'h208,      0,32'h0,        NOP));
        tbl.push_back(mk(1,0,0,32'h0,        1,32'h66666666, 0,32'h0,        0,32'h0,        NOP));
        tbl.push_back(mk(1,0,1,32'h300,      0,32'h0,        0,32'h0,        0,32'h0,        NOP));
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        1,32'h300,      0,32'h0,        NOP));
        tbl.push_back(mk(0,0,0,32'h0,        1,32'h77777777, 0,32'h0,        1,32'h300,      32'h77777777));
        tbl.push_back(mk(1,0,0,32'h0,        0,32'h0,        0,32'h0,        1,32'h300,      32'h77777777));
        tbl.push_back(mk(0,0,1,32'hFFFFFFFE, 0,32'h0,        0,32'h0,        0,32'h0,        NOP));
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        1,32'hFFFFFFFC, 0,32'h0,        NOP));
        tbl.push_back(mk(0,0,0,32'h0,        1,32'h88888888, 0,32'h0,        1,32'hFFFFFFFC, 32'h88888888));
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        1,32'h0,        0,32'h0,        NOP));
        tbl.push_back(mk(0,0,0,32'h0,        1,32'h99999999, 0,32'h0,        1,32'h0,        32'h99999999));
        tbl.push_back(mk(1,0,0,32'h0,        1,32'hAAAAAAAA, 0,32'h0,        1,32'h0,        32'h99999999));
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        1,32'h4,        0,32'h0,        NOP));

        // Directed table
        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].s, tbl[i].f, tbl[i].b, tbl[i].t, tbl[i].v, tbl[i].d);
            #1;
            chk($sformatf("vec%0d.req", i), {31'd0, imem_req}, {31'd0, tbl[i].er});
            if (tbl[i].er) chk($sformatf("vec%0d.addr", i), imem_addr, tbl[i].ea);
            @(posedge clk); #1;
            chk_ifid($sformatf("vec%0d", i), tbl[i].evld, tbl[i].epc, tbl[i].ein);
            @(negedge clk);
        end

        // Reset mid-request, then a late response that must be ignored
        do_reset();
        drive(0, 0, 0, '0, 0, '0); #1;
        chk("ar.req0", imem_addr, RPC);
        @(negedge clk); drive(0, 0, 0, '0, 1, 32'h00100093);
        @(negedge clk); drive(0, 0, 0, '0, 0, '0); #1;
        chk("ar.addr4", imem_addr, 32'h4);
        @(negedge clk); drive(0, 0, 0, '0, 0, '0);
        #2 rst_n = 1'b0; #1;
        chk("ar.async_addr", imem_addr, RPC);
        chk("ar.async_req", {31'd0, imem_req}, 32'd0);
        chk("ar.async_vld", {31'd0, if_id_valid}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        drive(0, 0, 0, '0, 1, 32'hBAD0BAD0); #1;
        chk("ar.req_after", {31'd0, imem_req}, 32'd1);
        chk("ar.addr_after", imem_addr, RPC);
        @(posedge clk); #1;
        chk_ifid("ar.late", 0, 32'h0, NOP);
        @(negedge clk); drive(0, 0, 0, '0, 0, '0);
        @(posedge clk); #1;
        chk("ar.wait_vld", {31'd0, if_id_valid}, 32'd0);
        @(negedge clk); drive(0, 0, 0, '0, 1, 32'h00A00113);
        @(posedge clk); #1;
        chk_ifid("ar.new", 1, RPC, 32'h00A00113);
        @(negedge clk);

        // Randomized traffic against the reference model
        begin
            bit          mem_busy, s, f, b, v, req_seen;
            int unsigned mem_cnt;
            logic [31:0] mem_data, t, d;
            mem_busy = 0; mem_cnt = 0; mem_data = '0;
            do_reset();
            model_reset();
            for (int unsigned cyc = 0; cyc < 4000; cyc++) begin
                v = 0; d = $urandom;
                if (mem_busy) begin
                    mem_cnt--;
                    if (mem_cnt == 0) begin
                        v = 1; d = mem_data; mem_busy = 0;
                    end
                end else if ($urandom_range(9) == 0) begin
                    v = 1;
                end
                s = ($urandom_range(3) == 0);
                f = ($urandom_range(9) == 0);
                b = ($urandom_range(11) == 0);
                t = $urandom;
                drive(s, f, b, t, v, d);
                #1;
                chk("rnd.req", {31'd0, imem_req},
                    {31'd0, (!m_out && !m_held && !s && !b)});
                if (!m_out && !m_held && !s && !b) chk("rnd.addr", imem_addr, m_pc);
                req_seen = imem_req;
                @(posedge clk);
                if (req_seen) begin
                    mem_busy = 1; mem_cnt = $urandom_range(1, 3); mem_data = $urandom;
                end
                model_step(s, f, b, t, v, d);
                #1;
                chk_ifid("rnd", m_ivld, m_ipc, m_iins);
                @(negedge clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): bubble instruction.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hold PC and IF/ID register (load-use stall).
REQ-006 flush_if_id  input  1  replace IF/ID contents with bubble.
REQ-007 branch_taken  input  1  redirect fetch to branch_target.
REQ-008 branch_target  input  32  redirect address.
REQ-009 imem_req  output  1  one-cycle fetch request pulse.
REQ-010 imem_addr  output  32  fetch address, valid while imem_req=1.
REQ-011 imem_valid  input  1  response strobe; at least 1 cycle after request.
REQ-012 imem_rdata  input  32  instruction word, valid with imem_valid.
REQ-013 if_id_pc  output  32  PC of instruction in IF/ID.
REQ-014 if_id_instr  output  32  instruction in IF/ID.
REQ-015 if_id_valid  output  1  IF/ID holds a real instruction.

Function
REQ-016 At most one memory request SHALL be outstanding; imem_valid outside S_WAIT/S_DROP SHALL be ignored.
REQ-017 FSM states SHALL be S_ISSUE, S_WAIT, S_DROP, S_HOLD.
REQ-018 S_ISSUE: when stall=0 and branch_taken=0, imem_req=1, imem_addr=pc, next S_WAIT; otherwise no request, stay.
REQ-019 S_WAIT, imem_valid=1: branch_taken=1 -> discard data, pc<=target, S_ISSUE; else stall=1 -> capture data/pc into one-entry buffer, S_HOLD; else deliver to IF/ID, pc<=pc+4, S_ISSUE.
REQ-020 S_WAIT, imem_valid=0: branch_taken=1 -> pc<=target, S_DROP; else stay.
REQ-021 S_DROP: on imem_valid discard data, next S_ISSUE; branch_taken here updates pc<=target, stays S_DROP.
REQ-022 S_HOLD: branch_taken=1 -> drop buffer, pc<=target, S_ISSUE; else stall=0 -> deliver buffer to IF/ID, pc<=pc+4, S_ISSUE; else stay.
REQ-023 Redirect SHALL load pc<={branch_target[31:2],2'b00}; pc+4 wraps modulo 2^32.
REQ-024 IF/ID update priority per cycle: flush_if_id=1 -> instr=NOP_INSTR, valid=0, pc=0; else stall=1 -> hold; else delivery -> load {pc,instr}, valid=1; else bubble (NOP_INSTR, valid=0).
REQ-025 flush_if_id SHALL override a same-cycle delivery; the delivered instruction is lost and pc still advances per REQ-019/022 unless branch_taken.
REQ-026 branch_taken SHALL take priority over stall in every state.
REQ-027 Minimum latency: request at cycle N, imem_valid at N+1 -> IF/ID valid at N+2; sustained throughput one instruction per 2 cycles.

Reset
REQ-028 rst_n=0 SHALL immediately force: state S_ISSUE, pc=RESET_PC, buffer empty, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0.
REQ-029 imem_req SHALL be 0 while rst_n=0; first request after release SHALL carry RESET_PC.
REQ-030 Reset during S_WAIT/S_DROP SHALL abandon the outstanding request; a late imem_valid in S_ISSUE is ignored.

Verification
REQ-031 Reset release, memory 1-cycle latency returning 0x00500093 at 0x0 -> imem_addr 0x0, then if_id_pc=0x0, if_id_instr=0x00500093, valid=1; next imem_addr=0x4.
REQ-032 stall=1 during response from 0x8 for 3 cycles -> IF/ID held, S_HOLD; stall drop -> if_id_pc=0x8 next edge, next imem_addr=0xC.
REQ-033 branch_taken=1, target 0x100, flush_if_id=1 while S_WAIT -> IF/ID bubble (valid=0, instr=0x00000013); pending response discarded; next imem_addr=0x100.
REQ-034 branch_taken=1 and imem_valid=1 same cycle, target 0x203 -> data discarded, next imem_addr=0x200.
REQ-035 pc=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000.
REQ-036 rst_n pulsed low mid-S_WAIT, late imem_valid after release -> ignored; imem_addr=RESET_PC, if_id_valid=0 until new response.
